irom_loader: RTL

//  Boot-time writer for the instruction ROM that the fetch/decode path reads. It accepts a byte stream
//  (from the host link), packs little-endian bytes into 32-bit instructions, writes them to consecutive

---
 rtl/irom_loader_pkg.sv | 21 ++
 rtl/irom_loader_byte_packer.sv | 27 ++
 rtl/irom_loader.sv | 124 ++++++++++++
 3 files changed

// File: rtl/irom_loader_pkg.sv
// Shared types for the IROM boot loader: FSM state encoding and state-class helper.
// LOADER_CHECKSUM_EN (see irom_loader.sv) is the only build option of this slice.
package irom_loader_pkg;

    typedef enum logic [2:0] {
        LDR_IDLE  = 3'd0,
        LDR_LEN0  = 3'd1,
        LDR_LEN1  = 3'd2,
        LDR_DATA  = 3'd3,
        LDR_WRITE = 3'd4,
        LDR_CHK   = 3'd5,
        LDR_DONE  = 3'd6,
        LDR_ERR   = 3'd7
    } ldr_state_t;

    // States in which the loader waits on the byte stream and the idle timer runs.
    function automatic logic is_waiting(input ldr_state_t s);
        return s inside {LDR_LEN0, LDR_LEN1, LDR_DATA, LDR_CHK};
    endfunction

endpackage

// File: rtl/irom_loader_byte_packer.sv
// Packs four little-endian stream bytes into one 32-bit instruction word.
// word_ready pulses combinationally with the 4th accepted byte; word is valid the cycle after.
module irom_loader_byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_data,
    output logic        word_ready,
    output logic [31:0] word
);
    logic [1:0] byte_idx;

    // NOTE: state elements use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            byte_idx <= '0;
            word     <= '0;
        end else if (byte_en) begin
            byte_idx <= byte_idx + 2'd1;
            word     <= {byte_data, word[31:8]};
        end
    end

    assign word_ready = byte_en && (byte_idx == 2'd3);

endmodule

// File: rtl/irom_loader.sv
// Boot-time IROM writer: length-prefixed byte stream -> consecutive 32-bit IROM words from 0.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte (CHK state).
module irom_loader
    import irom_loader_pkg::*;
#(
    parameter int ADDR_W         = 10,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              setup,
    output logic              irom_wr_en,
    output logic [ADDR_W-1:0] irom_wr_addr,
    output logic [31:0]       irom_wr_data,
    output logic [ADDR_W:0]   loaded_count,
    output logic              done,
    output logic              error
);
    localparam int          CNT_W  = ADDR_W + 1;
    localparam int          IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [16:0] DEPTH  = 17'd1 << ADDR_W;

    ldr_state_t        state, state_next;
    logic              xfer, start_ok, word_ready, timed_out;
    logic [7:0]        len_lo;
    logic [16:0]       len_n;
    logic [CNT_W-1:0]  len_words, count_plus1;
    logic [IDLE_W-1:0] idle_cnt;

    assign xfer        = byte_valid && byte_ready;
    assign start_ok    = start && (state inside {LDR_IDLE, LDR_DONE, LDR_ERR});
    assign len_n       = {1'b0, byte_data, len_lo};
    assign count_plus1 = loaded_count + CNT_W'(1);
    assign timed_out   = is_waiting(state) && !xfer && (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk) begin
        if (rst || start_ok)
            csum <= '0;
        else if (xfer && state != LDR_CHK)
            csum <= csum ^ byte_data;
    end
`endif

    irom_loader_byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (start_ok),
        .byte_en    (xfer && state == LDR_DATA),
        .byte_data  (byte_data),
        .word_ready (word_ready),
        .word       (irom_wr_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= LDR_IDLE;
            loaded_count <= '0;
            len_lo       <= '0;
            len_words    <= '0;
            idle_cnt     <= '0;
        end else begin
            state <= state_next;
            if (start_ok)
                loaded_count <= '0;
            else if (state == LDR_WRITE)
                loaded_count <= count_plus1;
            if (state == LDR_LEN0 && xfer)
                len_lo <= byte_data;
            if (state == LDR_LEN1 && xfer)
                len_words <= len_n[CNT_W-1:0];
            if (!is_waiting(state) || xfer)
                idle_cnt <= '0;
            else if (!timed_out)
                idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end

    // NOTE: next state defaults to the current state first, so no path leaves it unassigned.
    always_comb begin
        state_next = state;
        if (start_ok) begin
            state_next = LDR_LEN0;
        end else if (timed_out) begin
            state_next = LDR_ERR;
        end else begin
            case (state)
                LDR_LEN0: if (xfer) state_next = LDR_LEN1;
                LDR_LEN1: if (xfer) begin
                    if (len_n > DEPTH)       state_next = LDR_ERR;
                    else if (len_n == 17'd0) state_next = LDR_DONE;
                    else                     state_next = LDR_DATA;
                end
                LDR_DATA: if (word_ready) state_next = LDR_WRITE;
                LDR_WRITE: begin
                    if (count_plus1 != len_words) state_next = LDR_DATA;
`ifdef LOADER_CHECKSUM_EN
                    else                          state_next = LDR_CHK;
`else
                    else                          state_next = LDR_DONE;
`endif
                end
`ifdef LOADER_CHECKSUM_EN
                LDR_CHK: if (xfer) state_next = (byte_data == csum) ? LDR_DONE : LDR_ERR;
`endif
                default: state_next = state;
            endcase
        end
    end

    assign byte_ready   = is_waiting(state);
    assign setup        = is_waiting(state) || (state == LDR_WRITE);
    assign irom_wr_en   = (state == LDR_WRITE);
    assign irom_wr_addr = loaded_count[ADDR_W-1:0];
    assign done         = (state == LDR_DONE);
    assign error        = (state == LDR_ERR);

endmodule
